// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core types and constants
package mips_pkg;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - next-PC selection: jump over taken branch over sequential
module pc_next (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] branch_off;
  logic [31:0] jump_tgt;
  logic        unused_opcode;

  // Sign-extend the 16-bit immediate to 32 bits, then word-align it.
  assign branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jump_tgt      = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_tgt;
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, imem req/ack handshake, retire and PC update
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired_cnt
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  instr_q;
  logic [31:0]  cnt_q;

  assign pc_plus4 = pc_q + 32'd4;

  pc_next u_pc_next (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .branch   (branch),
    .jump     (jump),
    .zero     (zero),
    .next_pc  (pc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      cnt_q   <= 32'h0;
    end else if (state_q == S_REQ) begin
      if (imem_ack) begin
        instr_q <= imem_rdata;
        state_q <= S_HOLD;
      end
    end else begin
      // Ack seen here is stale or spurious; only stall gates the retire.
      if (!stall) begin
        pc_q    <= pc_d;
        cnt_q   <= cnt_q + 32'd1;
        state_q <= S_REQ;
      end
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign instr_valid = (state_q == S_HOLD);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch;
  logic        jump;
  logic        zero;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired_cnt;

  logic        hi_imem_req;
  logic [31:0] hi_imem_addr;
  logic [31:0] hi_instr;
  logic        hi_instr_valid;
  logic [31:0] hi_pc;
  logic [31:0] hi_pc_plus4;
  logic [31:0] hi_retired_cnt;

  int tests;
  int fails;

  instr_fetch u_dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retired_cnt (retired_cnt)
  );

  // Second instance placed in the 0x3xxx_xxxx region for the jump target test.
  instr_fetch #(.RESET_PC(32'h3000_0000)) u_dut_hi (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (hi_imem_req),
    .imem_addr   (hi_imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero),
    .instr       (hi_instr),
    .instr_valid (hi_instr_valid),
    .pc          (hi_pc),
    .pc_plus4    (hi_pc_plus4),
    .retired_cnt (hi_retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset;
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called from S_REQ: same-cycle ack, then retire with the given controls.
  task automatic fetch_retire(input logic [31:0] word, input logic b, input logic j, input logic z);
    imem_ack = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0; stall = 1'b0; branch = b; jump = j; zero = z;
    @(negedge clk);
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rst_req got %b exp 1", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got %h exp 00000000", imem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    tests++; if (instr !== 32'h0) begin fails++; $display("FAIL rst_instr got %h exp 00000000", instr); end
    tests++; if (retired_cnt !== 32'h0) begin fails++; $display("FAIL rst_cnt got %h exp 00000000", retired_cnt); end
    tests++; if (pc_plus4 !== 32'h4) begin fails++; $display("FAIL rst_pc_plus4 got %h exp 00000004", pc_plus4); end
  endtask

  task automatic test_sequential;
    for (int k = 0; k < 3; k++) begin
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'(k * 4)) begin
        fails++; $display("FAIL seq_req%0d got req=%b addr=%h exp req=1 addr=%h", k, imem_req, imem_addr, 32'(k * 4));
      end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0020 + 32'(k);
      @(negedge clk);
      imem_ack = 1'b0;
      tests++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0020 + 32'(k)) begin
        fails++; $display("FAIL seq_hold%0d got valid=%b instr=%h exp valid=1 instr=%h", k, instr_valid, instr, 32'h0000_0020 + 32'(k));
      end
      @(negedge clk);
    end
    tests++; if (retired_cnt !== 32'd3) begin fails++; $display("FAIL seq_cnt got %0d exp 3", retired_cnt); end
    tests++; if (pc !== 32'hC) begin fails++; $display("FAIL seq_pc got %h exp 0000000c", pc); end
  endtask

  task automatic test_ack_delay;
    fetch_retire(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin
        fails++; $display("FAIL dly_wait%0d got req=%b addr=%h valid=%b exp req=1 addr=00000010 valid=0", c, imem_req, imem_addr, instr_valid);
      end
      @(negedge clk);
    end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      fails++; $display("FAIL dly_ackcyc got req=%b addr=%h exp req=1 addr=00000010", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'hABCD_0123;
    @(negedge clk);
    imem_ack = 1'b0;
    tests++; if (instr_valid !== 1'b1 || instr !== 32'hABCD_0123 || imem_req !== 1'b0) begin
      fails++; $display("FAIL dly_valid got valid=%b instr=%h req=%b exp valid=1 instr=abcd0123 req=0", instr_valid, instr, imem_req);
    end
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0 || imem_addr !== 32'h14) begin
      fails++; $display("FAIL dly_retire got valid=%b addr=%h exp valid=0 addr=00000014", instr_valid, imem_addr);
    end
  endtask

  task automatic test_branch;
    fetch_retire(32'h0800_0008, 1'b0, 1'b1, 1'b0);
    tests++; if (pc !== 32'h20) begin fails++; $display("FAIL br_setup got %h exp 00000020", pc); end
    fetch_retire(32'h1000_FFFF, 1'b1, 1'b0, 1'b1);
    tests++; if (pc !== 32'h20) begin fails++; $display("FAIL br_taken got %h exp 00000020", pc); end
    fetch_retire(32'h1000_FFFF, 1'b1, 1'b0, 1'b0);
    tests++; if (pc !== 32'h24) begin fails++; $display("FAIL br_not_taken got %h exp 00000024", pc); end
  endtask

  task automatic test_jump;
    do_reset();
    tests++; if (hi_pc !== 32'h3000_0000) begin fails++; $display("FAIL j_hi_reset got %h exp 30000000", hi_pc); end
    fetch_retire(32'h0800_0040, 1'b0, 1'b1, 1'b0);
    tests++; if (hi_pc !== 32'h3000_0100) begin fails++; $display("FAIL j_hi got %h exp 30000100", hi_pc); end
    tests++; if (pc !== 32'h100) begin fails++; $display("FAIL j_lo got %h exp 00000100", pc); end
    fetch_retire(32'h0800_0040, 1'b1, 1'b1, 1'b1);
    tests++; if (hi_pc !== 32'h3000_0100) begin fails++; $display("FAIL j_prio got %h exp 30000100", hi_pc); end
    tests++; if (retired_cnt !== 32'd2) begin fails++; $display("FAIL j_cnt got %0d exp 2", retired_cnt); end
  endtask

  task automatic test_stall;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    stall = 1'b1; imem_rdata = 32'h1111_1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++; if (pc !== 32'h100 || instr !== 32'hDEAD_BEEF || retired_cnt !== 32'd2 || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        fails++; $display("FAIL stall%0d got pc=%h instr=%h cnt=%0d req=%b valid=%b exp pc=00000100 instr=deadbeef cnt=2 req=0 valid=1",
                          c, pc, instr, retired_cnt, imem_req, instr_valid);
      end
    end
    imem_ack = 1'b0; stall = 1'b0;
    @(negedge clk);
    tests++; if (pc !== 32'h104 || retired_cnt !== 32'd3 || imem_req !== 1'b1) begin
      fails++; $display("FAIL stall_release got pc=%h cnt=%0d req=%b exp pc=00000104 cnt=3 req=1", pc, retired_cnt, imem_req);
    end
  endtask

  task automatic test_reset_mid;
    fetch_retire(32'h0800_0010, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || retired_cnt !== 32'd4) begin
      fails++; $display("FAIL rmid_setup got req=%b addr=%h cnt=%0d exp req=1 addr=00000040 cnt=4", imem_req, imem_addr, retired_cnt);
    end
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0;
    tests++; if (instr_valid !== 1'b0 || pc !== 32'h0 || retired_cnt !== 32'h0 || instr !== 32'h0 || imem_req !== 1'b1) begin
      fails++; $display("FAIL rmid got valid=%b pc=%h cnt=%0d instr=%h req=%b exp valid=0 pc=00000000 cnt=0 instr=00000000 req=1",
                        instr_valid, pc, retired_cnt, instr, imem_req);
    end
  endtask

  task automatic test_wrap;
    fetch_retire(32'h1000_FFFE, 1'b1, 1'b0, 1'b1);
    tests++; if (pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_setup got %h exp fffffffc", pc); end
    tests++; if (pc_plus4 !== 32'h0) begin fails++; $display("FAIL wrap_plus4 got %h exp 00000000", pc_plus4); end
    fetch_retire(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    tests++; if (imem_addr !== 32'h0 || retired_cnt !== 32'd2) begin
      fails++; $display("FAIL wrap got addr=%h cnt=%0d exp addr=00000000 cnt=2", imem_addr, retired_cnt);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
    test_reset();
    test_sequential();
    test_ack_delay();
    test_branch();
    test_jump();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the MIPS core, directly upstream of the control unit and register file. Holds the PC, fetches one 32-bit word per instruction from instruction memory over a req/ack handshake, and presents it as `instr` (opcode = `instr[31:26]`) to decode. It updates the PC from the decoded `branch` and `jump` controls and the ALU `zero` flag when the instruction retires.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  sole clock, all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of the fetch; always equals `pc`.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle; ignored while `imem_req`=0.
- `imem_rdata`  in  32  fetched instruction word.
- `stall`  in  1  downstream hold; instruction is not retired while high.
- `branch`  in  1  decoded Branch (beq) for the presented `instr`.
- `jump`  in  1  decoded Jump for the presented `instr`.
- `zero`  in  1  ALU zero flag for the presented `instr`.
- `instr`  out  32  registered instruction word to decode.
- `instr_valid`  out  1  `instr` is valid and awaiting retire.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, combinational.
- `retired_cnt`  out  32  count of retired instructions.

## Operation
- FSM states: S_REQ, S_HOLD.
- S_REQ: `imem_req`=1, `instr_valid`=0. Stay in S_REQ until `imem_ack`=1. On ack, `instr` <= `imem_rdata` and the FSM goes to S_HOLD. Ack may arrive in the first cycle of the request.
- S_HOLD: `imem_req`=0, `instr_valid`=1.
  - Retire occurs when `stall`=0. On retire, `pc` <= next PC, `retired_cnt` += 1, and the FSM goes to S_REQ.
  - While `stall`=1, `pc`, `instr` and `retired_cnt` hold.
- Next PC, highest priority first:
  - `jump`=1: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - `branch`=1 and `zero`=1: `pc_plus4` + (sign-extended `instr[15:0]` << 2).
  - Otherwise: `pc_plus4`.
- Arithmetic: all PC sums are 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000. The branch offset is sign-extended to 32 bits before the shift. `retired_cnt` wraps silently.
- `branch`, `jump` and `zero` are sampled only in the retire cycle. At any other time they are don't-care.
- Memory contract: `imem_req` stays high and `imem_addr` stays stable until ack. The memory must tolerate a request dropped by reset.

## Timing
- Reset values: `pc`=RESET_PC, FSM=S_REQ, `instr`=32'h0, `instr_valid`=0, `retired_cnt`=0.
  - Consequently `imem_req`=1 and `imem_addr`=RESET_PC in the first cycle after reset.
- Best-case throughput is one instruction per 2 cycles: ack in the first S_REQ cycle, then retire in the first S_HOLD cycle.
- Latency from ack to `instr_valid`=1 is 1 cycle (registered).
- `instr_valid` falls the cycle after retire, and `imem_addr` shows the new PC in that same cycle.
- Reset asserted in any state, including mid-request or during a stall, takes priority over ack, retire and stall. All state returns to reset values on the next edge. An ack in the reset cycle is discarded.
- `imem_ack` asserted in S_HOLD is ignored.

## Structure
- Shared package `mips_pkg` holds:
  - the `fetch_state_t` enum (S_REQ, S_HOLD);
  - opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_ADDI=6'b001000, OP_J=6'b000010;
  - `RESET_PC_DEFAULT`.
- One combinational sub-module, `pc_next`, takes inputs `pc_plus4`, `instr`, `branch`, `jump`, `zero` and produces the next PC. It is unit-testable on its own.
- The top level contains the FSM, the PC, `instr` and counter registers, and the `pc_next` instance.

## Test plan
- Reset, then memory acks each request on the same cycle, with `stall`=0: addresses 0x0, 0x4, 0x8 are issued on cycles 1, 3, 5, and `retired_cnt`=3 after 6 cycles.
- Ack delayed 3 cycles at PC=0x10: `imem_req` stays high for 4 cycles with `imem_addr`=0x10 throughout, and `instr_valid` rises the cycle after ack.
- `instr`=0x1000_FFFF (beq, offset -1) at PC=0x20 with `branch`=1 and `zero`=1: next PC=0x20. With `zero`=0: next PC=0x24.
- `instr`=0x0800_0040 (j) at PC=0x3000_0000: next PC=0x3000_0100. With `jump`=1 and `branch`=1 at the same time, the jump wins.
- Hold `stall`=1 for 5 cycles in S_HOLD: `pc`, `instr` and `retired_cnt` are unchanged and `imem_req`=0. The retire happens on the first `stall`=0 cycle.
- Assert `rst` during a pending request at PC=0x40 while ack is high in the same cycle: `instr_valid`=0, `pc`=RESET_PC and `retired_cnt`=0 next cycle.
- Start at PC=0xFFFF_FFFC with no branch or jump: next address 0x0000_0000.
